// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer between rename and commit.
// Out-of-order completion, in-order single retire, flush on redirect/sys.
module rob_param #(
    parameter int DEPTH         = 64,
    parameter int NUM_ARCH_REGS = 32,
    parameter int NUM_PHYS_REGS = 64,
    parameter int PC_W          = 32,
    localparam int AW = $clog2(NUM_ARCH_REGS),
    localparam int PW = $clog2(NUM_PHYS_REGS),
    localparam int TW = $clog2(DEPTH)
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            alloc_valid,
    output logic            alloc_ready,
    input  logic            alloc_regWrite,
    input  logic [AW-1:0]   alloc_archReg,
    input  logic [PW-1:0]   alloc_physReg,
    input  logic [PW-1:0]   alloc_prevPhys,
    input  logic [PC_W-1:0] alloc_PC,
    input  logic            alloc_sys,
    output logic [TW-1:0]   alloc_tag,
    input  logic            complete_valid,
    input  logic [TW-1:0]   complete_tag,
    input  logic            complete_redirect,
    input  logic [PC_W-1:0] complete_target,
    input  logic            FLUSH_IN,
    output logic            commit_valid,
    output logic            commit_regWrite,
    output logic [AW-1:0]   commit_archReg,
    output logic [PW-1:0]   commit_physReg,
    output logic [PW-1:0]   commit_prevPhys,
    output logic [PC_W-1:0] commit_PC,
    output logic            FLUSH_OUT,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_PC,
    output logic [TW:0]     count
);

    typedef struct packed {
        logic            redirect;
        logic [PC_W-1:0] target;
        logic            sys;
        logic            reg_write;
        logic [AW-1:0]   arch;
        logic [PW-1:0]   phys;
        logic [PW-1:0]   prev;
        logic [PC_W-1:0] pc;
    } rob_entry_t;

    rob_entry_t       mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] done;
    logic [TW:0]      head;
    logic [TW:0]      tail;

    logic [TW-1:0] h_idx;
    logic [TW-1:0] t_idx;
    logic          full;
    logic          do_alloc;
    logic          do_cmpl;
    logic          do_commit;
    logic          do_clear;
    rob_entry_t    hd;

    assign h_idx       = head[TW-1:0];
    assign t_idx       = tail[TW-1:0];
    assign count       = tail - head;
    assign full        = (h_idx == t_idx) && (head[TW] != tail[TW]);
    assign alloc_ready = !full;
    assign alloc_tag   = t_idx;
    assign hd          = mem[h_idx];
    assign do_alloc    = alloc_valid && !full;
    assign do_cmpl     = complete_valid && vld[complete_tag];
    assign do_commit   = vld[h_idx] && done[h_idx];
    assign do_clear    = do_commit && (hd.redirect || hd.sys);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            vld             <= '0;
            done            <= '0;
            head            <= '0;
            tail            <= '0;
            commit_valid    <= 1'b0;
            commit_regWrite <= 1'b0;
            commit_archReg  <= '0;
            commit_physReg  <= '0;
            commit_prevPhys <= '0;
            commit_PC       <= '0;
            FLUSH_OUT       <= 1'b0;
            redirect_valid  <= 1'b0;
            redirect_PC     <= '0;
        end else begin
            commit_valid   <= 1'b0;
            FLUSH_OUT      <= 1'b0;
            redirect_valid <= 1'b0;
            if (FLUSH_IN) begin
                vld  <= '0;
                done <= '0;
                head <= '0;
                tail <= '0;
            end else begin
                if (do_cmpl)
                    done[complete_tag] <= 1'b1;
                if (do_alloc) begin
                    vld[t_idx]  <= 1'b1;
                    done[t_idx] <= 1'b0;
                    tail        <= tail + 1'b1;
                end
                if (do_commit) begin
                    commit_valid    <= 1'b1;
                    commit_regWrite <= hd.reg_write;
                    commit_archReg  <= hd.arch;
                    commit_physReg  <= hd.phys;
                    commit_prevPhys <= hd.prev;
                    commit_PC       <= hd.pc;
                    vld[h_idx]      <= 1'b0;
                    head            <= head + 1'b1;
                end
                // later assignments override any same-cycle allocation
                if (do_clear) begin
                    vld            <= '0;
                    done           <= '0;
                    head           <= '0;
                    tail           <= '0;
                    FLUSH_OUT      <= 1'b1;
                    redirect_valid <= hd.redirect;
                    if (hd.redirect)
                        redirect_PC <= hd.target;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!FLUSH_IN && do_alloc) begin
            mem[t_idx] <= '{
                redirect:  1'b0,
                target:    '0,
                sys:       alloc_sys,
                reg_write: alloc_regWrite,
                arch:      alloc_archReg,
                phys:      alloc_physReg,
                prev:      alloc_prevPhys,
                pc:        alloc_PC
            };
        end
        if (!FLUSH_IN && do_cmpl && complete_redirect) begin
            mem[complete_tag].redirect <= 1'b1;
            mem[complete_tag].target   <= complete_target;
        end
    end

endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: scenario tests plus random traffic against a queue model.
// Model tracks program-order entries; tags restart at 0 after any clear.
module tb_rob_param;
    localparam int DEPTH = 64;
    localparam int AW    = 5;
    localparam int PW    = 6;
    localparam int PC_W  = 32;
    localparam int TW    = 6;

    logic            CLK = 1'b0;
    logic            RESET = 1'b0;
    logic            alloc_valid;
    logic            alloc_ready;
    logic            alloc_regWrite;
    logic [AW-1:0]   alloc_archReg;
    logic [PW-1:0]   alloc_physReg;
    logic [PW-1:0]   alloc_prevPhys;
    logic [PC_W-1:0] alloc_PC;
    logic            alloc_sys;
    logic [TW-1:0]   alloc_tag;
    logic            complete_valid;
    logic [TW-1:0]   complete_tag;
    logic            complete_redirect;
    logic [PC_W-1:0] complete_target;
    logic            FLUSH_IN;
    logic            commit_valid;
    logic            commit_regWrite;
    logic [AW-1:0]   commit_archReg;
    logic [PW-1:0]   commit_physReg;
    logic [PW-1:0]   commit_prevPhys;
    logic [PC_W-1:0] commit_PC;
    logic            FLUSH_OUT;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_PC;
    logic [TW:0]     count;

    always #5 CLK = ~CLK;

    rob_param dut (
        .CLK(CLK), .RESET(RESET),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_regWrite(alloc_regWrite),
        .alloc_archReg(alloc_archReg),
        .alloc_physReg(alloc_physReg),
        .alloc_prevPhys(alloc_prevPhys),
        .alloc_PC(alloc_PC), .alloc_sys(alloc_sys),
        .alloc_tag(alloc_tag),
        .complete_valid(complete_valid),
        .complete_tag(complete_tag),
        .complete_redirect(complete_redirect),
        .complete_target(complete_target),
        .FLUSH_IN(FLUSH_IN),
        .commit_valid(commit_valid),
        .commit_regWrite(commit_regWrite),
        .commit_archReg(commit_archReg),
        .commit_physReg(commit_physReg),
        .commit_prevPhys(commit_prevPhys),
        .commit_PC(commit_PC),
        .FLUSH_OUT(FLUSH_OUT),
        .redirect_valid(redirect_valid),
        .redirect_PC(redirect_PC),
        .count(count)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          tag;
        logic        rw;
        logic [AW-1:0] ar;
        logic [PW-1:0] pr;
        logic [PW-1:0] pp;
        logic [31:0] pc;
        bit          sys;
        bit          done;
        bit          redir;
        logic [31:0] tgt;
    } ment_t;

    ment_t q[$];
    int    next_tag;
    logic  e_cv, e_rw, e_fo, e_rv;
    logic [AW-1:0] e_ar;
    logic [PW-1:0] e_pr, e_pp;
    logic [31:0]   e_pc, e_rpc;

    task automatic model_reset();
        q.delete();
        next_tag = 0;
        e_cv = 0; e_rw = 0; e_fo = 0; e_rv = 0;
        e_ar = '0; e_pr = '0; e_pp = '0;
        e_pc = '0; e_rpc = '0;
    endtask

    task automatic model_step();
        ment_t h;
        ment_t n;
        bit com;
        bit acc;
        e_cv = 0; e_fo = 0; e_rv = 0;
        if (FLUSH_IN) begin
            q.delete();
            next_tag = 0;
            return;
        end
        com = q.size() > 0 && q[0].done;
        if (com) h = q[0];
        acc = alloc_valid && q.size() < DEPTH;
        if (complete_valid) begin
            foreach (q[i]) begin
                if (q[i].tag == int'(complete_tag)) begin
                    q[i].done = 1;
                    if (complete_redirect) begin
                        q[i].redir = 1;
                        q[i].tgt = complete_target;
                    end
                end
            end
        end
        if (com) begin
            void'(q.pop_front());
            e_cv = 1; e_rw = h.rw; e_ar = h.ar;
            e_pr = h.pr; e_pp = h.pp; e_pc = h.pc;
            if (h.redir || h.sys) begin
                e_fo = 1;
                e_rv = h.redir;
                if (h.redir) e_rpc = h.tgt;
                q.delete();
                next_tag = 0;
                acc = 0;
            end
        end
        if (acc) begin
            n.tag = next_tag; n.rw = alloc_regWrite;
            n.ar = alloc_archReg; n.pr = alloc_physReg;
            n.pp = alloc_prevPhys; n.pc = alloc_PC;
            n.sys = alloc_sys; n.done = 0;
            n.redir = 0; n.tgt = '0;
            q.push_back(n);
            next_tag = (next_tag + 1) % DEPTH;
        end
    endtask

    task automatic idle_inputs();
        alloc_valid = 0; alloc_regWrite = 0;
        alloc_archReg = '0; alloc_physReg = '0;
        alloc_prevPhys = '0; alloc_PC = '0;
        alloc_sys = 0; complete_valid = 0;
        complete_tag = '0; complete_redirect = 0;
        complete_target = '0; FLUSH_IN = 0;
    endtask

    task automatic set_alloc(input logic [31:0] pc, input bit sys);
        alloc_valid = 1;
        alloc_regWrite = 1'($urandom);
        alloc_archReg = AW'($urandom);
        alloc_physReg = PW'($urandom);
        alloc_prevPhys = PW'($urandom);
        alloc_PC = pc;
        alloc_sys = sys;
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic flush_cycle();
        idle_inputs();
        FLUSH_IN = 1;
        cycle();
        FLUSH_IN = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        RESET = 0;
        #12;
        checks++;
        if (commit_valid !== 0 || FLUSH_OUT !== 0 || redirect_valid !== 0) begin
            errors++;
            $display("FAIL reset_pulses cv=%b fo=%b rv=%b need 0",
                     commit_valid, FLUSH_OUT, redirect_valid);
        end
        checks++;
        if (count !== 0 || alloc_ready !== 1 || alloc_tag !== 0) begin
            errors++;
            $display("FAIL reset_state count=%0d rdy=%b tag=%0d need 0/1/0",
                     count, alloc_ready, alloc_tag);
        end
        checks++;
        if (commit_PC !== 0 || redirect_PC !== 0 || commit_physReg !== 0) begin
            errors++;
            $display("FAIL reset_data pc=%h rpc=%h pr=%0d need 0",
                     commit_PC, redirect_PC, commit_physReg);
        end
        @(negedge CLK);
        RESET = 1;
        cycle();
    endtask

    task automatic test_in_order();
        logic [31:0] pcs[3] = '{32'h100, 32'h104, 32'h108};
        int ord[3] = '{2, 0, 1};
        for (int i = 0; i < 3; i++) begin
            set_alloc(pcs[i], 0);
            checks++;
            if (alloc_tag !== TW'(i)) begin
                errors++;
                $display("FAIL inord_tag got=%0d need=%0d", alloc_tag, i);
            end
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            complete_valid = 1;
            complete_tag = TW'(ord[i]);
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (commit_valid !== 1 || commit_PC !== pcs[i]) begin
                errors++;
                $display("FAIL inord_commit%0d cv=%b pc=%h need 1/%h",
                         i, commit_valid, commit_PC, pcs[i]);
            end
            checks++;
            if (commit_physReg !== e_pr || commit_archReg !== e_ar) begin
                errors++;
                $display("FAIL inord_data%0d pr=%0d ar=%0d need %0d/%0d",
                         i, commit_physReg, commit_archReg, e_pr, e_ar);
            end
            cycle();
        end
        checks++;
        if (commit_valid !== 0 || count !== 0) begin
            errors++;
            $display("FAIL inord_after cv=%b count=%0d need 0/0",
                     commit_valid, count);
        end
    endtask

    task automatic test_full_wrap();
        flush_cycle();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(32'h1000 + 32'(4 * i), 0);
            cycle();
        end
        checks++;
        if (count !== 7'd64 || alloc_ready !== 0) begin
            errors++;
            $display("FAIL full_state count=%0d rdy=%b need 64/0",
                     count, alloc_ready);
        end
        set_alloc(32'hdead, 0);
        cycle();
        checks++;
        if (count !== 7'd64) begin
            errors++;
            $display("FAIL full_65th count=%0d need 64", count);
        end
        idle_inputs();
        complete_valid = 1;
        complete_tag = '0;
        cycle();
        idle_inputs();
        cycle();
        checks++;
        if (commit_valid !== 1 || commit_PC !== 32'h1000) begin
            errors++;
            $display("FAIL full_commit cv=%b pc=%h need 1/1000",
                     commit_valid, commit_PC);
        end
        checks++;
        if (alloc_ready !== 1 || count !== 7'd63) begin
            errors++;
            $display("FAIL full_free rdy=%b count=%0d need 1/63",
                     alloc_ready, count);
        end
        set_alloc(32'h3000, 0);
        checks++;
        if (alloc_tag !== 0) begin
            errors++;
            $display("FAIL wrap_tag got=%0d need 0", alloc_tag);
        end
        cycle();
        idle_inputs();
        checks++;
        if (count !== 7'd64 || alloc_ready !== 0) begin
            errors++;
            $display("FAIL wrap_full count=%0d rdy=%b need 64/0",
                     count, alloc_ready);
        end
        flush_cycle();
    endtask

    task automatic test_redirect();
        flush_cycle();
        for (int i = 0; i < 4; i++) begin
            set_alloc(32'h200 + 32'(4 * i), 0);
            cycle();
        end
        idle_inputs();
        complete_valid = 1;
        complete_tag = 1;
        complete_redirect = 1;
        complete_target = 32'h2000;
        cycle();
        idle_inputs();
        complete_valid = 1;
        complete_tag = 0;
        cycle();
        idle_inputs();
        cycle();
        checks++;
        if (commit_valid !== 1 || commit_PC !== 32'h200 || FLUSH_OUT !== 0) begin
            errors++;
            $display("FAIL redir_first cv=%b pc=%h fo=%b need 1/200/0",
                     commit_valid, commit_PC, FLUSH_OUT);
        end
        cycle();
        checks++;
        if (commit_valid !== 1 || commit_PC !== 32'h204 || FLUSH_OUT !== 1) begin
            errors++;
            $display("FAIL redir_commit cv=%b pc=%h fo=%b need 1/204/1",
                     commit_valid, commit_PC, FLUSH_OUT);
        end
        checks++;
        if (redirect_valid !== 1 || redirect_PC !== 32'h2000) begin
            errors++;
            $display("FAIL redir_pc rv=%b rpc=%h need 1/2000",
                     redirect_valid, redirect_PC);
        end
        checks++;
        if (count !== 0 || alloc_ready !== 1) begin
            errors++;
            $display("FAIL redir_empty count=%0d rdy=%b need 0/1",
                     count, alloc_ready);
        end
        for (int t = 2; t < 4; t++) begin
            complete_valid = 1;
            complete_tag = TW'(t);
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (commit_valid !== 0 || FLUSH_OUT !== 0 || redirect_valid !== 0) begin
                errors++;
                $display("FAIL redir_stale cv=%b fo=%b rv=%b need 0",
                         commit_valid, FLUSH_OUT, redirect_valid);
            end
        end
    endtask

    task automatic test_sys();
        set_alloc(32'h300, 1);
        cycle();
        set_alloc(32'h304, 0);
        cycle();
        idle_inputs();
        complete_valid = 1;
        complete_tag = 0;
        cycle();
        idle_inputs();
        cycle();
        checks++;
        if (commit_valid !== 1 || commit_PC !== 32'h300) begin
            errors++;
            $display("FAIL sys_commit cv=%b pc=%h need 1/300",
                     commit_valid, commit_PC);
        end
        checks++;
        if (FLUSH_OUT !== 1 || redirect_valid !== 0 || count !== 0) begin
            errors++;
            $display("FAIL sys_flush fo=%b rv=%b count=%0d need 1/0/0",
                     FLUSH_OUT, redirect_valid, count);
        end
        complete_valid = 1;
        complete_tag = 1;
        cycle();
        idle_inputs();
        cycle();
        checks++;
        if (commit_valid !== 0 || FLUSH_OUT !== 0) begin
            errors++;
            $display("FAIL sys_after cv=%b fo=%b need 0/0",
                     commit_valid, FLUSH_OUT);
        end
    endtask

    task automatic test_flush_in();
        flush_cycle();
        for (int i = 0; i < 5; i++) begin
            set_alloc(32'h400 + 32'(4 * i), 0);
            cycle();
        end
        idle_inputs();
        complete_valid = 1;
        complete_tag = 1;
        cycle();
        complete_tag = 3;
        cycle();
        idle_inputs();
        checks++;
        if (count !== 5) begin
            errors++;
            $display("FAIL flush_pre count=%0d need 5", count);
        end
        FLUSH_IN = 1;
        cycle();
        FLUSH_IN = 0;
        checks++;
        if (count !== 0 || commit_valid !== 0 || FLUSH_OUT !== 0
            || redirect_valid !== 0) begin
            errors++;
            $display("FAIL flush_in count=%0d cv=%b fo=%b rv=%b need 0",
                     count, commit_valid, FLUSH_OUT, redirect_valid);
        end
        complete_valid = 1;
        complete_tag = 1;
        cycle();
        idle_inputs();
        cycle();
        checks++;
        if (commit_valid !== 0 || count !== 0) begin
            errors++;
            $display("FAIL flush_oldtag cv=%b count=%0d need 0/0",
                     commit_valid, count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            if ($urandom_range(99) < 60)
                set_alloc($urandom, $urandom_range(99) < 2);
            if ($urandom_range(99) < 55) begin
                complete_valid = 1;
                if (q.size() > 0 && $urandom_range(9) != 0)
                    complete_tag = TW'(q[$urandom_range(q.size() - 1)].tag);
                else
                    complete_tag = TW'($urandom);
                complete_redirect = $urandom_range(99) < 4;
                complete_target = $urandom;
            end
            FLUSH_IN = $urandom_range(199) == 0;
            cycle();
            checks++;
            if (commit_valid !== e_cv || FLUSH_OUT !== e_fo
                || redirect_valid !== e_rv) begin
                errors++;
                $display("FAIL rnd_pulse n=%0d got=%b%b%b need=%b%b%b", n,
                         commit_valid, FLUSH_OUT, redirect_valid,
                         e_cv, e_fo, e_rv);
            end
            checks++;
            if (count !== 7'(q.size()) || alloc_ready !== (q.size() < DEPTH)
                || alloc_tag !== TW'(next_tag)) begin
                errors++;
                $display("FAIL rnd_occ n=%0d cnt=%0d rdy=%b tag=%0d need %0d/%0d",
                         n, count, alloc_ready, alloc_tag, q.size(), next_tag);
            end
            checks++;
            if (commit_PC !== e_pc || commit_regWrite !== e_rw
                || commit_archReg !== e_ar || commit_physReg !== e_pr
                || commit_prevPhys !== e_pp) begin
                errors++;
                $display("FAIL rnd_data n=%0d pc=%h pp=%0d need %h/%0d",
                         n, commit_PC, commit_prevPhys, e_pc, e_pp);
            end
            checks++;
            if (redirect_PC !== e_rpc) begin
                errors++;
                $display("FAIL rnd_rpc n=%0d got=%h need=%h",
                         n, redirect_PC, e_rpc);
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        flush_cycle();
        set_alloc(32'h500, 0);
        cycle();
        set_alloc(32'h504, 0);
        cycle();
        idle_inputs();
        complete_valid = 1;
        complete_tag = 0;
        cycle();
        idle_inputs();
        cycle();
        checks++;
        if (commit_valid !== 1 || commit_PC !== 32'h500) begin
            errors++;
            $display("FAIL areset_pre cv=%b pc=%h need 1/500",
                     commit_valid, commit_PC);
        end
        #1 RESET = 0;
        #1;
        checks++;
        if (commit_valid !== 0 || commit_PC !== 0 || commit_physReg !== 0
            || commit_prevPhys !== 0 || commit_archReg !== 0
            || commit_regWrite !== 0) begin
            errors++;
            $display("FAIL areset_commit cv=%b pc=%h need 0/0",
                     commit_valid, commit_PC);
        end
        checks++;
        if (count !== 0 || alloc_ready !== 1 || alloc_tag !== 0
            || FLUSH_OUT !== 0 || redirect_valid !== 0 || redirect_PC !== 0) begin
            errors++;
            $display("FAIL areset_state cnt=%0d rdy=%b tag=%0d need 0/1/0",
                     count, alloc_ready, alloc_tag);
        end
        model_reset();
        @(negedge CLK);
        RESET = 1;
        cycle();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full_wrap();
        test_redirect();
        test_sys();
        test_flush_in();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
